// File: rtl/la_andn_pipe.sv
// Pipelined N-input AND/NAND reduction with valid/ready handshaking.
// Each stage folds one partial product into the next; the final stage drives z directly.
module la_andn_pipe #(
    parameter int unsigned N      = 8,
    parameter int unsigned STAGES = 2,
    parameter bit          INVERT = 1'b0,
    parameter              PROP   = "DEFAULT"
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         in_valid,
    input  logic [N-1:0] in,
    output logic         in_ready,
    output logic         out_valid,
    output logic         z,
    input  logic         out_ready
);

    localparam int unsigned W    = STAGES;
    localparam int unsigned LAST = STAGES - 1;

    if (N < 2 || STAGES < 1 || STAGES > N - 1) begin : g_bad_cfg
        $error("la_andn_pipe(%s): requires N >= 2 and 1 <= STAGES <= N-1", PROP);
    end

    logic [W-1:0]      grp;
    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] vld_src;
    logic [STAGES-1:0] acc;
    logic              fin;

    // Operand split into W contiguous groups, one AND per group
    always_comb begin
        grp = '1;
        for (int unsigned i = 0; i < N; i++) begin
            if (!in[i]) grp[(i * W) / N] = 1'b0;
        end
    end

    // Stage k can take a new entry when empty or when its contents move on
    always_comb begin
        logic take;
        acc       = '0;
        take      = !vld[LAST] || out_ready;
        acc[LAST] = take;
        for (int k = int'(LAST) - 1; k >= 0; k--) begin
            take   = !vld[k] || take;
            acc[k] = take;
        end
    end

    assign vld_src   = STAGES'({vld, in_valid});
    assign in_ready  = acc[0];
    assign out_valid = vld[LAST];

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            vld <= '0;
        end else begin
            vld <= (acc & vld_src) | (~acc & vld);
        end
    end

    if (STAGES > 1) begin : g_multi
        logic [W-1:0] data [STAGES-1];
        logic [W-1:0] src  [STAGES-1];

        // Each later stage ANDs the two lowest partials and shifts the rest down
        always_comb begin
            src[0] = grp;
            for (int k = 1; k < int'(STAGES) - 1; k++) begin
                src[k]    = {1'b1, data[k-1][W-1:1]};
                src[k][0] = data[k-1][0] & data[k-1][1];
            end
        end

        always_ff @(posedge clk or negedge nreset) begin
            if (!nreset) begin
                for (int k = 0; k < int'(STAGES) - 1; k++) data[k] <= '0;
            end else begin
                for (int k = 0; k < int'(STAGES) - 1; k++) begin
                    if (acc[k]) data[k] <= src[k];
                end
            end
        end

        assign fin = &data[STAGES-2];
    end else begin : g_single
        assign fin = &grp;
    end

    // Final stage: z is forced low whenever the stage loads a bubble
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            z <= 1'b0;
        end else if (acc[LAST]) begin
            z <= vld_src[LAST] & (fin ^ INVERT);
        end
    end

endmodule
